// File: rtl/mac_array.sv
// N-lane multiply-accumulate engine: pairs independently strobed input/weight vectors and
// emits one dot-product of LEN products per lane. Define MAC_SAT_EN for saturating accumulation.
module mac_array #(
  parameter int unsigned K     = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned LEN   = 16,
  parameter int unsigned ACC_W = 2*K + $clog2(LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*K-1:0]     in,
  input  logic [N*K-1:0]     w,
  input  logic               data_strobe_in,
  input  logic               data_strobe_w,
  input  logic               clear,
  output logic [N*ACC_W-1:0] mac_out,
  output logic               out_valid,
  output logic               ovr_flag,
  output logic               sat_flag
);
  localparam int unsigned P_W   = 2*K;
  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic             in_pend, w_pend;
  logic [N*K-1:0]   in_hold, w_hold;
  logic             prod_valid;
  logic [P_W-1:0]   prod [N];
  logic [ACC_W-1:0] acc [N];
  logic [CNT_W-1:0] count;

  logic             pair_c, in_load_c, w_load_c, ovr_set_c;
  logic             in_pend_nx_c, w_pend_nx_c;
  logic [N*K-1:0]   pair_in_c, pair_w_c;
  logic [P_W-1:0]   prod_nx_c [N];
  logic [ACC_W-1:0] acc_sum_c [N];

  // Operand pairing: a held operand always pairs with the opposite port first.
  always_comb begin
    pair_c       = 1'b0;
    pair_in_c    = in;
    pair_w_c     = w;
    in_pend_nx_c = in_pend;
    w_pend_nx_c  = w_pend;
    in_load_c    = 1'b0;
    w_load_c     = 1'b0;
    ovr_set_c    = 1'b0;
    if (data_strobe_in && data_strobe_w && !in_pend && !w_pend) begin
      pair_c = 1'b1;
    end else if (in_pend && data_strobe_w) begin
      pair_c       = 1'b1;
      pair_in_c    = in_hold;
      in_pend_nx_c = data_strobe_in;
      in_load_c    = data_strobe_in;
    end else if (w_pend && data_strobe_in) begin
      pair_c      = 1'b1;
      pair_w_c    = w_hold;
      w_pend_nx_c = data_strobe_w;
      w_load_c    = data_strobe_w;
    end else begin
      if (data_strobe_in) begin
        in_load_c    = 1'b1;
        in_pend_nx_c = 1'b1;
        ovr_set_c    = in_pend;
      end
      if (data_strobe_w) begin
        w_load_c    = 1'b1;
        w_pend_nx_c = 1'b1;
        ovr_set_c   = ovr_set_c | w_pend;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_nx_c[i] = P_W'(pair_in_c[i*K +: K]) * P_W'(pair_w_c[i*K +: K]);
    end
  end

`ifdef MAC_SAT_EN
  localparam int unsigned S_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
  logic [S_W-1:0] sum_c [N];
  logic           sat_hit_c;

  // Saturating add: any bit above ACC_W clamps the lane to all-ones.
  always_comb begin
    sat_hit_c = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_c[i] = S_W'(acc[i]) + S_W'(prod[i]);
      if (sum_c[i][S_W-1:ACC_W] != '0) begin
        acc_sum_c[i] = '1;
        sat_hit_c    = 1'b1;
      end else begin
        acc_sum_c[i] = sum_c[i][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (clear) begin
      sat_flag <= 1'b0;
    end else if (prod_valid && sat_hit_c) begin
      sat_flag <= 1'b1;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_sum_c[i] = acc[i] + ACC_W'(prod[i]);
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Pairing holds, product stage and accumulator/result stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pend    <= 1'b0;
      w_pend     <= 1'b0;
      in_hold    <= '0;
      w_hold     <= '0;
      prod_valid <= 1'b0;
      count      <= '0;
      mac_out    <= '0;
      out_valid  <= 1'b0;
      ovr_flag   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else if (clear) begin
      in_pend    <= 1'b0;
      w_pend     <= 1'b0;
      prod_valid <= 1'b0;
      count      <= '0;
      out_valid  <= 1'b0;
      ovr_flag   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else begin
      in_pend    <= in_pend_nx_c;
      w_pend     <= w_pend_nx_c;
      ovr_flag   <= ovr_flag | ovr_set_c;
      prod_valid <= pair_c;
      out_valid  <= 1'b0;
      if (in_load_c) in_hold <= in;
      if (w_load_c)  w_hold  <= w;
      if (pair_c) begin
        for (int i = 0; i < N; i++) begin
          prod[i] <= prod_nx_c[i];
        end
      end
      if (prod_valid) begin
        if (count == LAST) begin
          count     <= '0;
          out_valid <= 1'b1;
          for (int i = 0; i < N; i++) begin
            mac_out[i*ACC_W +: ACC_W] <= acc_sum_c[i];
            acc[i]                    <= '0;
          end
        end else begin
          count <= count + CNT_W'(1);
          for (int i = 0; i < N; i++) begin
            acc[i] <= acc_sum_c[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// Directed self-checking bench for mac_array (N=2, K=4, LEN=4, ACC_W=8).
module tb_mac_array;
  localparam int unsigned K     = 4;
  localparam int unsigned N     = 2;
  localparam int unsigned LEN   = 4;
  localparam int unsigned ACC_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*K-1:0]     in_bus;
  logic [N*K-1:0]     w_bus;
  logic               strobe_in, strobe_w, clear;
  logic [N*ACC_W-1:0] mac_out;
  logic               out_valid, ovr_flag, sat_flag;

  int checks    = 0;
  int failures  = 0;
  int pulse_cnt = 0;

  mac_array #(.K(K), .N(N), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in            (in_bus),
    .w             (w_bus),
    .data_strobe_in(strobe_in),
    .data_strobe_w (strobe_w),
    .clear         (clear),
    .mac_out       (mac_out),
    .out_valid     (out_valid),
    .ovr_flag      (ovr_flag),
    .sat_flag      (sat_flag)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later, tallying result pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (out_valid) pulse_cnt++;
  endtask

  task automatic drive(input logic si, input logic sw, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] b0, input logic [3:0] b1);
    strobe_in = si;
    strobe_w  = sw;
    in_bus    = {a1, a0};
    w_bus     = {b1, b0};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    checks++;
    if ({mac_out, out_valid, ovr_flag, sat_flag} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {mac_out, out_valid, ovr_flag, sat_flag});
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out !== 16'h0404) begin
      failures++;
      $display("FAIL reset_prerun got=%b/%h exp=1/0404", out_valid, mac_out);
    end
    drive(1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0);
    step();
    step();
    checks++;
    if (ovr_flag !== 1'b1) begin
      failures++;
      $display("FAIL reset_ovr_pre got=%b exp=1", ovr_flag);
    end
    drive(1'b1, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mac_out, out_valid, ovr_flag, sat_flag} !== 19'd0) begin
      failures++;
      $display("FAIL reset_midrun got=%h exp=0", {mac_out, out_valid, ovr_flag, sat_flag});
    end
    step();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || mac_out !== 16'h0000 || ovr_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%b/%h/%b exp=0/0000/0", out_valid, mac_out, ovr_flag);
    end
  endtask

  task automatic test_paired();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd3, 4'd5, 4'd2, 4'd1);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL paired_early got=%b exp=0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out[7:0] !== 8'd24 || mac_out[15:8] !== 8'd20) begin
      failures++;
      $display("FAIL paired_result got=%b/%0d/%0d exp=1/24/20", out_valid, mac_out[7:0], mac_out[15:8]);
    end
    step();
    step();
    checks++;
    if (pulse_cnt - p0 !== 1 || mac_out !== 16'h1418) begin
      failures++;
      $display("FAIL paired_hold got=%0d/%h exp=1/1418", pulse_cnt - p0, mac_out);
    end
  endtask

  task automatic test_split();
    drive(1'b1, 1'b0, 4'd4, 4'd4, 4'd0, 4'd0);
    step();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    drive(1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 4'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out !== 16'h0C0C || ovr_flag !== 1'b0) begin
      failures++;
      $display("FAIL split_12 got=%b/%h/%b exp=1/0c0c/0", out_valid, mac_out, ovr_flag);
    end
    drive(1'b1, 1'b0, 4'd2, 4'd2, 4'd0, 4'd0);
    step();
    drive(1'b1, 1'b0, 4'd7, 4'd7, 4'd0, 4'd0);
    step();
    drive(1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 4'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out !== 16'h0707 || ovr_flag !== 1'b1) begin
      failures++;
      $display("FAIL split_ovr got=%b/%h/%b exp=1/0707/1", out_valid, mac_out, ovr_flag);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int idx [4];
    logic [15:0] val [4];
    n = 0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = -1;
      val[i] = '0;
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
      else       drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      step();
      if (out_valid && n < 4) begin
        idx[n] = i;
        val[n] = mac_out;
        n++;
      end
    end
    checks++;
    if (n !== 2 || idx[0] !== 4 || idx[1] !== 8) begin
      failures++;
      $display("FAIL b2b_timing got=%0d@%0d,%0d exp=2@4,8", n, idx[0], idx[1]);
    end
    checks++;
    if (val[0] !== 16'h0404 || val[1] !== 16'h0404) begin
      failures++;
      $display("FAIL b2b_values got=%h,%h exp=0404,0404", val[0], val[1]);
    end
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3);
      step();
    end
    drive(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    checks++;
    if (ovr_flag !== 1'b0 || mac_out !== 16'h0404) begin
      failures++;
      $display("FAIL abort_clear got=%b/%h exp=0/0404", ovr_flag, mac_out);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++;
    if (pulse_cnt - p0 !== 0 || mac_out !== 16'h0404) begin
      failures++;
      $display("FAIL abort_hold got=%0d/%h exp=0/0404", pulse_cnt - p0, mac_out);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out !== 16'h1010) begin
      failures++;
      $display("FAIL abort_fresh got=%b/%h exp=1/1010", out_valid, mac_out);
    end
    p0 = pulse_cnt;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mac_out !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got=%h/%b exp=0000/0", mac_out, out_valid);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out !== 16'h1010 || pulse_cnt - p0 !== 1) begin
      failures++;
      $display("FAIL abort_after_reset got=%b/%h/%0d exp=1/1010/1", out_valid, mac_out, pulse_cnt - p0);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_out;
    logic        exp_sat;
`ifdef MAC_SAT_EN
    exp_out = 16'hFFFF;
    exp_sat = 1'b1;
`else
    exp_out = 16'h8484;
    exp_sat = 1'b0;
`endif
    checks++;
    if (sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_initial got=%b exp=0", sat_flag);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd15, 4'd15, 4'd15, 4'd15);
      step();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    checks++;
    if (out_valid !== 1'b1 || mac_out !== exp_out || sat_flag !== exp_sat) begin
      failures++;
      $display("FAIL sat_result got=%b/%h/%b exp=1/%h/%b", out_valid, mac_out, sat_flag, exp_out, exp_sat);
    end
  endtask

  initial begin
    test_reset();
    test_paired();
    test_split();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
